// File: rtl/udp_tx_arb_pkg.sv
// Shared types and constants for the UDP transmit arbiter slice.
//   arb_state_e  : frame-ownership FSM states (IDLE / HDR / PAYLOAD)
//   *_W          : field widths of the UDP/IP header and payload stream
//   DEFAULT_TTL  : IP TTL used when the top is not overridden
//   idx_width()  : width of an index into n requesters, never below 1
package udp_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } arb_state_e;

  localparam int IP_W        = 32;
  localparam int PORT_W      = 16;
  localparam int LEN_W       = 16;
  localparam int DATA_W      = 8;
  localparam int DEFAULT_TTL = 64;

  // A single requester still needs a 1-bit pointer so no zero-width vectors appear.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_arbiter.sv
// Purely combinational round-robin pick.
//   req    : request vector, one bit per requester
//   rr_ptr : index that has highest priority this round
//   grant  : one-hot winner, the first set req bit at or after rr_ptr
//            (searching upward with wrap); all zero when req is zero
module rr_arbiter
  import udp_tx_arb_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int PTR_W = idx_width(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PORTS-1:0] grant
);

  int   ptr_i;
  logic found;

  // Rank each requester by its distance above rr_ptr (mod PORTS) and take the
  // closest one. Comparing distances keeps every bit select constant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    ptr_i = int'(rr_ptr);
    for (int k = 0; k < PORTS; k++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (!found && req[i] && (((i - ptr_i + PORTS) % PORTS) == k)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing the stack's single UDP transmit interface
// between PORTS frame sources. One requester owns the output from its header
// handshake until its tlast beat handshakes; priority rotates between frames.
//   sys_clk / rst                 : clock, synchronous active-high reset
//   local_ip                      : source IP for every output header
//   s_hdr_* / s_dest_ip .. s_length : per-requester header channel (sliced)
//   s_t*                          : per-requester payload stream (sliced)
//   m_hdr_* / m_ip_* / m_*_port / m_length / m_checksum : header to the stack
//   m_t*                          : payload stream to the stack
//   grant                         : one-hot current owner, 0 when idle
//   busy                          : high whenever a frame is in flight
module udp_tx_arbiter
  import udp_tx_arb_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int TTL   = DEFAULT_TTL
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic [IP_W-1:0]         local_ip,
  input  logic [PORTS-1:0]        s_hdr_valid,
  output logic [PORTS-1:0]        s_hdr_ready,
  input  logic [IP_W*PORTS-1:0]   s_dest_ip,
  input  logic [PORT_W*PORTS-1:0] s_source_port,
  input  logic [PORT_W*PORTS-1:0] s_dest_port,
  input  logic [LEN_W*PORTS-1:0]  s_length,
  input  logic [DATA_W*PORTS-1:0] s_tdata,
  input  logic [PORTS-1:0]        s_tvalid,
  input  logic [PORTS-1:0]        s_tlast,
  input  logic [PORTS-1:0]        s_tuser,
  output logic [PORTS-1:0]        s_tready,
  output logic                    m_hdr_valid,
  input  logic                    m_hdr_ready,
  output logic [5:0]              m_ip_dscp,
  output logic [1:0]              m_ip_ecn,
  output logic [7:0]              m_ip_ttl,
  output logic [IP_W-1:0]         m_ip_source_ip,
  output logic [IP_W-1:0]         m_ip_dest_ip,
  output logic [PORT_W-1:0]       m_source_port,
  output logic [PORT_W-1:0]       m_dest_port,
  output logic [LEN_W-1:0]        m_length,
  output logic [15:0]             m_checksum,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  output logic                    m_tuser,
  input  logic                    m_tready,
  output logic [PORTS-1:0]        grant,
  output logic                    busy
);

  localparam int PTR_W = idx_width(PORTS);

  arb_state_e       state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PORTS-1:0] arb_grant;
  logic [PTR_W-1:0] sel;
  logic             last_hs;

  logic [IP_W-1:0]   dest_ip_s   [PORTS];
  logic [PORT_W-1:0] src_port_s  [PORTS];
  logic [PORT_W-1:0] dst_port_s  [PORTS];
  logic [LEN_W-1:0]  length_s    [PORTS];
  logic [DATA_W-1:0] tdata_s     [PORTS];

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_slice
    assign dest_ip_s[gi]  = s_dest_ip[gi*IP_W +: IP_W];
    assign src_port_s[gi] = s_source_port[gi*PORT_W +: PORT_W];
    assign dst_port_s[gi] = s_dest_port[gi*PORT_W +: PORT_W];
    assign length_s[gi]   = s_length[gi*LEN_W +: LEN_W];
    assign tdata_s[gi]    = s_tdata[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .PORTS (PORTS),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req    (s_hdr_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (arb_grant)
  );

  // Index of the owner; falls back to 0 when idle so the muxes show slice 0.
  always_comb begin
    sel = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_q[i]) sel = PTR_W'(i);
    end
  end

  assign last_hs = (state_q == PAYLOAD) && s_tvalid[sel] && s_tlast[sel] && m_tready;

  // State register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|s_hdr_valid) begin
          grant_d = arb_grant;
          state_d = HDR;
        end
      end
      HDR: begin
        if (m_hdr_ready) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (last_hs) begin
          // Owner drops to lowest priority for the next round.
          rr_ptr_d = (sel == PTR_W'(PORTS - 1)) ? '0 : sel + 1'b1;
          grant_d  = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: readies depend only on m_*ready, state and grant, never on s_*valid.
  always_comb begin
    m_hdr_valid = 1'b0;
    s_hdr_ready = '0;
    m_tvalid    = 1'b0;
    s_tready    = '0;
    case (state_q)
      HDR: begin
        m_hdr_valid = 1'b1;
        s_hdr_ready = grant_q & {PORTS{m_hdr_ready}};
      end
      PAYLOAD: begin
        m_tvalid = s_tvalid[sel];
        s_tready = grant_q & {PORTS{m_tready}};
      end
      default: ;
    endcase
  end

  assign m_ip_dscp      = 6'd0;
  assign m_ip_ecn       = 2'd0;
  assign m_ip_ttl       = 8'(TTL);
  assign m_checksum     = 16'd0;
  assign m_ip_source_ip = local_ip;
  assign m_ip_dest_ip   = dest_ip_s[sel];
  assign m_source_port  = src_port_s[sel];
  assign m_dest_port    = dst_port_s[sel];
  assign m_length       = length_s[sel];
  assign m_tdata        = tdata_s[sel];
  assign m_tlast        = s_tlast[sel];
  assign m_tuser        = s_tuser[sel];
  assign grant          = grant_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter with two requesters.
module tb_udp_tx_arbiter;
  localparam int P = 2;

  logic            sys_clk = 1'b0;
  logic            rst;
  logic [31:0]     local_ip;
  logic [P-1:0]    s_hdr_valid, s_hdr_ready;
  logic [32*P-1:0] s_dest_ip;
  logic [16*P-1:0] s_source_port, s_dest_port, s_length;
  logic [8*P-1:0]  s_tdata;
  logic [P-1:0]    s_tvalid, s_tlast, s_tuser, s_tready;
  logic            m_hdr_valid, m_hdr_ready;
  logic [5:0]      m_ip_dscp;
  logic [1:0]      m_ip_ecn;
  logic [7:0]      m_ip_ttl;
  logic [31:0]     m_ip_source_ip, m_ip_dest_ip;
  logic [15:0]     m_source_port, m_dest_port, m_length, m_checksum;
  logic [7:0]      m_tdata;
  logic            m_tvalid, m_tlast, m_tuser, m_tready;
  logic [P-1:0]    grant;
  logic            busy;

  udp_tx_arbiter #(.PORTS(P), .TTL(64)) dut (
    .sys_clk(sys_clk), .rst(rst), .local_ip(local_ip),
    .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
    .s_dest_ip(s_dest_ip), .s_source_port(s_source_port),
    .s_dest_port(s_dest_port), .s_length(s_length),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tready(s_tready),
    .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
    .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn), .m_ip_ttl(m_ip_ttl),
    .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
    .m_source_port(m_source_port), .m_dest_port(m_dest_port),
    .m_length(m_length), .m_checksum(m_checksum),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tready(m_tready),
    .grant(grant), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // One frame record: inputs for the source and the expected output image.
  typedef struct {
    int          port;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] len;
    int          n;      // payload beats
    logic [63:0] d;      // byte i at d[8*i +: 8]
    logic        user;   // tuser on the last beat
  } frame_t;

  frame_t frames [0:127];
  int     src_list [P][0:63];
  int     head [P];
  int     tail [P];
  int     cur [P];
  logic   hdr_pend [P];
  int     beat [P];
  int     exp_q [$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   obeat   = 0;
  logic in_frame = 1'b0;
  logic mon_en = 1'b0;
  logic rand_bp = 1'b0;
  logic prev_arb = 1'b0;
  logic prev_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic set_frame(input int idx, input int port, input logic [31:0] dip,
                           input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len,
                           input int n, input logic [63:0] d, input logic user);
    frames[idx].port = port; frames[idx].dip = dip; frames[idx].sp = sp;
    frames[idx].dp = dp; frames[idx].len = len; frames[idx].n = n;
    frames[idx].d = d; frames[idx].user = user;
  endtask

  task automatic enqueue(input int idx);
    int p;
    p = frames[idx].port;
    src_list[p][tail[p]] = idx;
    tail[p]++;
  endtask

  function automatic logic src_busy();
    logic b;
    b = 1'b0;
    for (int p = 0; p < P; p++) if (cur[p] >= 0 || head[p] < tail[p]) b = 1'b1;
    return b;
  endfunction

  // Source models: offer header and first beat together, advance on handshakes.
  task automatic drive_sources(input logic [P-1:0] hs_h, input logic [P-1:0] hs_t);
    frame_t f;
    for (int p = 0; p < P; p++) begin
      if (cur[p] >= 0) begin
        if (hs_h[p]) hdr_pend[p] = 1'b0;
        if (hs_t[p]) begin
          beat[p]++;
          if (beat[p] == frames[cur[p]].n) cur[p] = -1;
        end
      end
      if (cur[p] < 0 && head[p] < tail[p]) begin
        cur[p] = src_list[p][head[p]];
        head[p]++;
        hdr_pend[p] = 1'b1;
        beat[p] = 0;
      end
      if (cur[p] >= 0) begin
        f = frames[cur[p]];
        s_hdr_valid[p]            = hdr_pend[p];
        s_dest_ip[p*32 +: 32]     = f.dip;
        s_source_port[p*16 +: 16] = f.sp;
        s_dest_port[p*16 +: 16]   = f.dp;
        s_length[p*16 +: 16]      = f.len;
        s_tvalid[p]               = 1'b1;
        s_tdata[p*8 +: 8]         = f.d[beat[p]*8 +: 8];
        s_tlast[p]                = (beat[p] == f.n - 1);
        s_tuser[p]                = f.user && (beat[p] == f.n - 1);
      end else begin
        s_hdr_valid[p]            = 1'b0;
        s_dest_ip[p*32 +: 32]     = '0;
        s_source_port[p*16 +: 16] = '0;
        s_dest_port[p*16 +: 16]   = '0;
        s_length[p*16 +: 16]      = '0;
        s_tvalid[p]               = 1'b0;
        s_tdata[p*8 +: 8]         = '0;
        s_tlast[p]                = 1'b0;
        s_tuser[p]                = 1'b0;
      end
    end
  endtask

  task automatic bench_clear();
    for (int p = 0; p < P; p++) begin
      head[p] = 0; tail[p] = 0; cur[p] = -1; hdr_pend[p] = 1'b0; beat[p] = 0;
    end
    exp_q.delete();
    in_frame = 1'b0; obeat = 0; prev_arb = 1'b0; prev_last = 1'b0;
  endtask

  // Output-side checks, evaluated mid-cycle.
  task automatic monitor();
    frame_t f;
    chk("ready_gate", 64'({s_hdr_ready & ~grant, s_tready & ~grant}), 64'(0));
    chk("no_payload_in_hdr", 64'(m_hdr_valid & m_tvalid), 64'(0));
    if (prev_arb)  chk("arb_latency", 64'(m_hdr_valid), 64'(1));
    if (prev_last) chk("idle_after_last", 64'(busy), 64'(0));
    prev_arb  = !busy && (s_hdr_valid != '0);
    prev_last = 1'b0;
    if (m_hdr_valid && m_hdr_ready) begin
      if (exp_q.size() == 0) fail("unexpected_hdr", "header handshake with no frame expected");
      else begin
        f = frames[exp_q[0]];
        chk("hdr_grant", 64'(grant), 64'(1) << f.port);
        chk("hdr_dest_ip", 64'(m_ip_dest_ip), 64'(f.dip));
        chk("hdr_src_port", 64'(m_source_port), 64'(f.sp));
        chk("hdr_dst_port", 64'(m_dest_port), 64'(f.dp));
        chk("hdr_length", 64'(m_length), 64'(f.len));
        chk("hdr_ttl", 64'(m_ip_ttl), 64'(64));
        chk("hdr_src_ip", 64'(m_ip_source_ip), 64'(local_ip));
        chk("hdr_consts", 64'({m_ip_dscp, m_ip_ecn, m_checksum}), 64'(0));
        in_frame = 1'b1;
        obeat = 0;
      end
    end
    if (m_tvalid && m_tready) begin
      if (!in_frame || exp_q.size() == 0) fail("unexpected_beat", "payload beat outside a frame");
      else begin
        f = frames[exp_q[0]];
        chk("beat_data", 64'(m_tdata), 64'(f.d[obeat*8 +: 8]));
        chk("beat_last", 64'(m_tlast), 64'(obeat == f.n - 1));
        chk("beat_user", 64'(m_tuser), 64'(f.user && (obeat == f.n - 1)));
        obeat++;
        if (m_tlast) begin
          $display("[TB] frame %0d port %0d delivered, %0d beats", exp_q[0], f.port, obeat);
          void'(exp_q.pop_front());
          in_frame  = 1'b0;
          prev_last = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    logic [P-1:0] hs_h, hs_t;
    @(negedge sys_clk);
    hs_h = s_hdr_valid & s_hdr_ready;
    hs_t = s_tvalid & s_tready;
    if (mon_en) monitor();
    @(posedge sys_clk);
    #1;
    drive_sources(hs_h, hs_t);
    if (rand_bp) begin
      m_hdr_ready = ($urandom_range(0, 2) != 0);
      m_tready    = ($urandom_range(0, 3) != 0);
    end else begin
      m_hdr_ready = 1'b1;
      m_tready    = 1'b1;
    end
  endtask

  task automatic run_until_done(input int maxc);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || src_busy()) && c < maxc) begin
      cycle();
      c++;
    end
    if (c >= maxc) fail("timeout", $sformatf("%0d frames still pending", exp_q.size()));
  endtask

  initial begin
    int c;
    // Directed vector table.
    set_frame(0, 0, 32'hC0A8020A, 16'd1234, 16'd5000, 16'd12, 4, 64'h04030201, 1'b0);
    set_frame(1, 0, 32'hC0A80101, 16'd100,  16'd200,  16'd11, 3, 64'hCCBBAA,   1'b1);
    set_frame(2, 1, 32'hC0A80202, 16'd300,  16'd400,  16'd10, 2, 64'h2211,     1'b0);
    set_frame(3, 0, 32'h0A000010, 16'd7,    16'd8,    16'd12, 4, 64'h44332211, 1'b0);
    set_frame(4, 1, 32'h0A000020, 16'd9,    16'd10,   16'd10, 2, 64'h6655,     1'b1);
    set_frame(5, 0, 32'h0A000030, 16'd11,   16'd12,   16'd9,  1, 64'h77,       1'b1);
    set_frame(6, 0, 32'h0A000040, 16'd13,   16'd14,   16'd16, 8, 64'h8877665544332211, 1'b0);
    for (int i = 0; i < 100; i++) begin
      set_frame(7 + i, i % 2, $urandom, 16'($urandom_range(0, 65535)),
                16'($urandom_range(0, 65535)), 16'($urandom_range(9, 16)),
                int'($urandom_range(1, 8)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    local_ip = 32'h0A000001;
    bench_clear();
    drive_sources('0, '0);
    m_hdr_ready = 1'b1;
    m_tready    = 1'b1;

    // Reset with requests and readies asserted: nothing may be granted or accepted.
    rst = 1'b1;
    s_hdr_valid = '1;
    s_tvalid    = '1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_m_hdr_valid", 64'(m_hdr_valid), 64'(0));
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_s_ready", 64'({s_hdr_ready, s_tready}), 64'(0));
    chk("rst_ttl", 64'(m_ip_ttl), 64'(64));
    @(posedge sys_clk);
    #1;
    drive_sources('0, '0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Both request together after reset: port 0 (frame 1) then port 1 (frame 2).
    for (int i = 1; i <= 2; i++) begin
      enqueue(i);
      exp_q.push_back(i);
    end
    run_until_done(200);

    // Single port-0 frame: 192.168.2.10, 1234->5000, length 12, bytes 01..04.
    enqueue(0);
    exp_q.push_back(0);
    run_until_done(200);
    chk("idle_grant", 64'(grant), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));

    // Port 0 has frames 3 and 5 queued; port 1 raises frame 4 during frame 3.
    // rr_ptr points at port 1 once frame 3 ends, so the order is 3, 4, 5.
    enqueue(3);
    enqueue(5);
    for (int i = 3; i <= 5; i++) exp_q.push_back(i);
    repeat (4) cycle();
    enqueue(4);
    run_until_done(200);
    cycle();

    // Reset mid-frame: frame 6 on port 0 is cut after two beats.
    // rr_ptr would be 1 here, so reset must bring it back to 0.
    enqueue(6);
    exp_q.push_back(6);
    c = 0;
    while (!(in_frame && obeat >= 2) && c < 50) begin
      cycle();
      c++;
    end
    if (c >= 50) fail("timeout", "frame 6 never reached its third beat");
    chk("pre_rst_busy", 64'(busy), 64'(1));
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("mid_rst_grant", 64'(grant), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_s_tready", 64'(s_tready), 64'(0));
    rst = 1'b0;
    bench_clear();
    drive_sources('0, '0);
    mon_en = 1'b1;

    // 100 frames with random backpressure, both ports always pending: strict
    // alternation starting with port 0 because rr_ptr was reset.
    for (int i = 0; i < 100; i++) begin
      enqueue(7 + i);
      exp_q.push_back(7 + i);
    end
    rand_bp = 1'b1;
    run_until_done(20000);
    rand_bp = 1'b0;
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
